muldiv_sequencer: RTL and testbench

Multi-cycle execution controller for the RV32M operations in the Execute stage.
- Accepts a MUL/DIV/REM request from Execute and latches the operands.
- Sequences a MUL_LAT-deep registered multiply path or a 32-iteration restoring divider.
- Holds the pipeline via stall_o until the result is ready, then presents it for one cycle with done_o.
- Sits alongside the ALU; stall_o feeds the hazard unit (StallF/StallD/hold E) and result_o feeds the EX/MEM ALU-result mux.

---
 rtl/muldiv_sequencer.sv | 173 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// RV32M execution controller: sequences a MUL_LAT-deep multiply pipe or a
// 32-step restoring divider and stalls Execute until the result is ready.
module muldiv_sequencer #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] operand1_i,
  input  logic [XLEN-1:0] operand2_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic            busy_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e          state_q;
  logic [4:0]      cnt_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] op1_q;
  logic [XLEN-1:0] op2_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] result_q;
  logic            done_q;
  logic            busy_q;

  function automatic logic [XLEN-1:0] abs_if(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // Accept-time decode of the divide corner cases that bypass the iterator
  logic            acc_signed;
  logic            acc_div0;
  logic            acc_ovf;
  logic [XLEN-1:0] acc_special;

  assign acc_signed  = ~funct3_i[0];
  assign acc_div0    = (operand2_i == '0);
  assign acc_ovf     = acc_signed && (operand1_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                       (operand2_i == '1);
  assign acc_special = funct3_i[1] ? (acc_div0 ? operand1_i : '0)
                                   : (acc_div0 ? '1 : {1'b1, {(XLEN-1){1'b0}}});

  // Multiply: 33x33 signed product of sign/zero-extended latched operands
  logic signed [XLEN:0]     mul_a;
  logic signed [XLEN:0]     mul_b;
  logic signed [2*XLEN+1:0] mul_prod;
  logic [2*XLEN+1:0]        mul_tap;
  logic [XLEN-1:0]          mul_res;

  assign mul_a    = {((f3_q == 3'b001) || (f3_q == 3'b010)) & op1_q[XLEN-1], op1_q};
  assign mul_b    = {(f3_q == 3'b001) & op2_q[XLEN-1], op2_q};
  assign mul_prod = mul_a * mul_b;

  if (MUL_LAT == 1) begin : g_mul_direct
    assign mul_tap = mul_prod;
  end else begin : g_mul_pipe
    logic [2*XLEN+1:0] mpipe_q [MUL_LAT-1];

    always_ff @(posedge clk) begin
      mpipe_q[0] <= mul_prod;
      for (int i = 1; i < MUL_LAT - 1; i++) begin
        mpipe_q[i] <= mpipe_q[i-1];
      end
    end

    assign mul_tap = mpipe_q[MUL_LAT-2];
  end

  assign mul_res = (f3_q[1:0] == 2'b00) ? mul_tap[XLEN-1:0] : mul_tap[2*XLEN-1:XLEN];

  // Divide: one restoring step per cycle on magnitudes, sign fix-up on the last step
  logic            div_signed;
  logic [XLEN-1:0] dvsr_abs;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_trial;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] quo_nxt;
  logic [XLEN-1:0] div_res;

  assign div_signed = ~f3_q[0];
  assign dvsr_abs   = abs_if(op2_q, div_signed);
  assign div_shift  = {rem_q, quo_q[XLEN-1]};
  assign div_trial  = div_shift - {1'b0, dvsr_abs};
  assign rem_nxt    = div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0];
  assign quo_nxt    = {quo_q[XLEN-2:0], ~div_trial[XLEN]};
  assign div_res    = f3_q[1] ? neg_if(rem_nxt, div_signed & op1_q[XLEN-1])
                              : neg_if(quo_nxt, div_signed & (op1_q[XLEN-1] ^ op2_q[XLEN-1]));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else if (flush_i) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (valid_i) begin
            f3_q   <= funct3_i;
            op1_q  <= operand1_i;
            op2_q  <= operand2_i;
            busy_q <= 1'b1;
            if (!funct3_i[2]) begin
              state_q <= S_MUL;
              cnt_q   <= 5'(MUL_LAT - 1);
            end else if (acc_div0 || acc_ovf) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              result_q <= acc_special;
            end else begin
              state_q <= S_DIV;
              cnt_q   <= 5'd31;
              quo_q   <= abs_if(operand1_i, acc_signed);
              rem_q   <= '0;
            end
          end
        end
        S_MUL: begin
          if (cnt_q == '0) begin
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            result_q <= mul_res;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        S_DIV: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          if (cnt_q == '0) begin
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            result_q <= div_res;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign stall_o  = valid_i & (state_q != S_DONE) & ~flush_i;
  assign done_o   = done_q;
  assign busy_o   = busy_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed bench for muldiv_sequencer against an arithmetic model.
module tb_muldiv_sequencer;
  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        flush_i;
  logic [2:0]  funct3_i;
  logic [31:0] operand1_i;
  logic [31:0] operand2_i;
  logic        stall_o;
  logic        done_o;
  logic        busy_o;
  logic [31:0] result_o;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_res;

  always #5 clk = ~clk;

  muldiv_sequencer #(.XLEN(32), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .funct3_i(funct3_i),
    .operand1_i(operand1_i), .operand2_i(operand2_i), .flush_i(flush_i),
    .stall_o(stall_o), .done_o(done_o), .busy_o(busy_o), .result_o(result_o)
  );

  function automatic logic [31:0] ref_calc(input logic [2:0] f3, input logic [31:0] a, b);
    longint      sp;
    logic [63:0] p;
    int          sa, sbv;
    sa = a;
    sbv = b;
    p = '0;
    case (f3)
      3'b000, 3'b001: begin sp = longint'(sa) * longint'(sbv); p = sp; end
      3'b010:         begin sp = longint'(sa) * longint'({32'h0, b}); p = sp; end
      3'b011:         p = {32'h0, a} * {32'h0, b};
      default:        p = '0;
    endcase
    case (f3)
      3'b000:                 return p[31:0];
      3'b001, 3'b010, 3'b011: return p[63:32];
      3'b100: return (b == 0) ? 32'hFFFFFFFF :
                     (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h80000000 : 32'(sa / sbv);
      3'b101: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'b110: return (b == 0) ? a :
                     (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h0 : 32'(sa % sbv);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, b);
    if (!f3[2]) return MUL_LAT + 1;
    if (b == 0) return 1;
    if (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  // Drives one request with valid held; operands are scrambled after accept.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, b, input bit wait_edge,
                       output logic [31:0] res, output int lat, output bit stall_bad);
    res = 'x;
    lat = -1;
    stall_bad = 0;
    if (wait_edge) @(negedge clk);
    valid_i = 1'b1;
    funct3_i = f3;
    operand1_i = a;
    operand2_i = b;
    #1;
    if (stall_o !== 1'b1) stall_bad = 1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      operand1_i = $urandom;
      operand2_i = $urandom;
      #1;
      if (done_o === 1'b1) begin
        lat = c;
        res = result_o;
        if (stall_o !== 1'b0) stall_bad = 1;
        break;
      end
      if (stall_o !== 1'b1 || busy_o !== 1'b1) stall_bad = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({done_o, busy_o, stall_o, result_o} !== 35'h0) begin
      failures++;
      $display("FAIL reset_outputs done=%b busy=%b stall=%b result=%h exp all 0",
               done_o, busy_o, stall_o, result_o);
    end
    rst = 1'b0;
    last_res = 32'h0;
  endtask

  task automatic test_mul();
    logic [31:0] res; int lat; bit sb;
    do_op(3'b000, 32'h00000007, 32'hFFFFFFFD, 1, res, lat, sb);
    valid_i = 1'b0;
    checks++;
    if (res !== 32'hFFFFFFEB) begin failures++; $display("FAIL mul_7x-3 got=%h exp=FFFFFFEB", res); end
    checks++;
    if (lat != MUL_LAT + 1) begin failures++; $display("FAIL mul_latency got=%0d exp=%0d", lat, MUL_LAT + 1); end
    checks++;
    if (sb) begin failures++; $display("FAIL mul_stall_profile got=bad exp=high until done"); end
    last_res = 32'hFFFFFFEB;
  endtask

  task automatic test_mulh();
    logic [31:0] res; int lat; bit sb;
    logic [31:0] exp_t [3] = '{32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFE};
    for (int k = 0; k < 3; k++) begin
      do_op(3'(k + 1), 32'hFFFFFFFF, 32'hFFFFFFFF, 1, res, lat, sb);
      valid_i = 1'b0;
      checks++;
      if (res !== exp_t[k] || lat != MUL_LAT + 1 || sb) begin
        failures++;
        $display("FAIL mulh_f3_%0d got=%h lat=%0d stallbad=%0d exp=%h lat=%0d",
                 k + 1, res, lat, sb, exp_t[k], MUL_LAT + 1);
      end
      last_res = exp_t[k];
    end
  endtask

  task automatic test_div();
    logic [31:0] res; int lat; bit sb;
    logic [2:0]  f_t [3] = '{3'b100, 3'b110, 3'b101};
    logic [31:0] a_t [3] = '{32'hFFFFFFEC, 32'hFFFFFFEC, 32'd100};
    logic [31:0] b_t [3] = '{32'd3, 32'd3, 32'd7};
    logic [31:0] e_t [3] = '{32'hFFFFFFFA, 32'hFFFFFFFE, 32'd14};
    for (int k = 0; k < 3; k++) begin
      do_op(f_t[k], a_t[k], b_t[k], 1, res, lat, sb);
      valid_i = 1'b0;
      checks++;
      if (res !== e_t[k]) begin failures++; $display("FAIL div_case_%0d got=%h exp=%h", k, res, e_t[k]); end
      checks++;
      if (lat != 33 || sb) begin
        failures++;
        $display("FAIL div_timing_%0d lat=%0d stallbad=%0d exp lat=33", k, lat, sb);
      end
      last_res = e_t[k];
    end
  endtask

  task automatic test_div_special();
    logic [31:0] res; int lat; bit sb;
    logic [2:0]  f_t [4] = '{3'b101, 3'b110, 3'b100, 3'b110};
    logic [31:0] a_t [4] = '{32'h1234ABCD, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] b_t [4] = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] e_t [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
    for (int k = 0; k < 4; k++) begin
      do_op(f_t[k], a_t[k], b_t[k], 1, res, lat, sb);
      valid_i = 1'b0;
      checks++;
      if (res !== e_t[k] || lat != 1 || sb) begin
        failures++;
        $display("FAIL div_special_%0d got=%h lat=%0d stallbad=%0d exp=%h lat=1", k, res, lat, sb, e_t[k]);
      end
      last_res = e_t[k];
    end
  endtask

  task automatic test_flush();
    logic [31:0] res; int lat; bit sb;
    @(negedge clk);
    valid_i = 1'b1; funct3_i = 3'b100; operand1_i = 32'hFFFFFFEC; operand2_i = 32'd3;
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", stall_o); end
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== last_res) begin
      failures++;
      $display("FAIL flush_abort busy=%b done=%b result=%h exp busy=0 done=0 result=%h",
               busy_o, done_o, result_o, last_res);
    end
    do_op(3'b000, 32'd12345, 32'd678, 0, res, lat, sb);
    valid_i = 1'b0;
    checks++;
    if (res !== 32'd8369910 || lat != MUL_LAT + 1 || sb) begin
      failures++;
      $display("FAIL flush_then_mul got=%h lat=%0d stallbad=%0d exp=%h", res, lat, sb, 32'd8369910);
    end
    last_res = 32'd8369910;
  endtask

  task automatic test_back_to_back();
    logic [31:0] res; int lat; bit sb;
    logic [31:0] a, b, c, d;
    a = $urandom; b = $urandom; c = $urandom; d = $urandom_range(1, 1000);
    do_op(3'b000, a, b, 1, res, lat, sb);
    checks++;
    if (res !== ref_calc(3'b000, a, b) || lat != MUL_LAT + 1 || sb) begin
      failures++;
      $display("FAIL b2b_mul got=%h lat=%0d exp=%h", res, lat, ref_calc(3'b000, a, b));
    end
    do_op(3'b101, c, d, 1, res, lat, sb);
    valid_i = 1'b0;
    checks++;
    if (res !== c / d || lat != 33 || sb) begin
      failures++;
      $display("FAIL b2b_divu got=%h lat=%0d stallbad=%0d exp=%h lat=33", res, lat, sb, c / d);
    end
    last_res = c / d;
  endtask

  task automatic test_valid_drop();
    int lat;
    logic [31:0] res;
    lat = -1;
    res = 'x;
    @(negedge clk);
    valid_i = 1'b1; funct3_i = 3'b111; operand1_i = 32'd1000003; operand2_i = 32'd97;
    @(negedge clk);
    valid_i = 1'b0;
    for (int c = 2; c <= 40; c++) begin
      @(negedge clk);
      #1;
      if (done_o === 1'b1) begin lat = c; res = result_o; break; end
    end
    checks++;
    if (res !== 32'd1000003 % 32'd97 || lat != 33) begin
      failures++;
      $display("FAIL valid_drop got=%h lat=%0d exp=%h lat=33", res, lat, 32'd1000003 % 32'd97);
    end
    last_res = 32'd1000003 % 32'd97;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    valid_i = 1'b1; funct3_i = 3'b100; operand1_i = 32'd1000; operand2_i = 32'd7;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || result_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid done=%b busy=%b result=%h exp all 0", done_o, busy_o, result_o);
    end
    rst = 1'b0;
    last_res = 32'h0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(1, 50));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] res, a, b, e; int lat, el; bit sb;
    logic [2:0] f3;
    for (int n = 0; n < 40; n++) begin
      f3 = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      e = ref_calc(f3, a, b);
      el = ref_lat(f3, a, b);
      do_op(f3, a, b, 1, res, lat, sb);
      valid_i = 1'b0;
      checks++;
      if (res !== e || lat != el || sb) begin
        failures++;
        $display("FAIL random_%0d f3=%0d a=%h b=%h got=%h lat=%0d stallbad=%0d exp=%h lat=%0d",
                 n, f3, a, b, res, lat, sb, e, el);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; funct3_i = 3'b0;
    operand1_i = 32'h0; operand2_i = 32'h0; last_res = 32'h0;
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_div_special();
    test_flush();
    test_back_to_back();
    test_valid_drop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
